// File: rtl/parity_arbiter_pkg.sv
// Shared state encoding and default sizes for the parity arbiter slice.
package parity_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int CW_DEF   = 8;

endpackage

// File: rtl/parity_core.sv
// Registered parity unit: par updates to XOR-reduce(word) on the edge where en is high.
// One-cycle latency, no backpressure; par holds its value while en is low.
module parity_core #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] word,
  output logic          par
);

  logic par_q;
  logic par_d;

  always_comb begin
    par_d = par_q;
    if (en) begin
      par_d = ^word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par = par_q;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one parity unit; request-to-valid latency 2 cycles.
// Result held stable until res_ready; no arbitration while a result is outstanding.
module parity_arbiter
  import parity_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int IDW  = 2,
  parameter int CW   = CW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*DW-1:0]  data,
  output logic [NREQ-1:0]     ack,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [IDW-1:0]      res_id,
  output logic                res_par,
  output logic [CW-1:0]       odd_cnt,
  output logic                busy
);

  // Nearest asserted requester after 'last', wrapping modulo NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] g;
    int idx;
    g = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (r[idx]) begin
        g = idx[IDW-1:0];
      end
    end
    return g;
  endfunction

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [DW-1:0]   word_q, word_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            res_valid_q, res_valid_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [CW-1:0]   odd_cnt_q, odd_cnt_d;
  logic [IDW-1:0]  grant;
  logic            core_en;
  logic            core_par;

  assign grant = rr_pick(req, last_q);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    word_d      = word_q;
    id_d        = id_q;
    ack_d       = '0;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    odd_cnt_d   = odd_cnt_q;
    core_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          word_d  = data[grant*DW +: DW];
          id_d    = grant;
          ack_d   = NREQ'(1) << grant;
          last_d  = grant;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        core_en     = 1'b1;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (core_par && (odd_cnt_q != {CW{1'b1}})) begin
            odd_cnt_d = odd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      last_q      <= IDW'(NREQ - 1);
      word_q      <= '0;
      id_q        <= '0;
      ack_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      odd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      word_q      <= word_d;
      id_q        <= id_d;
      ack_q       <= ack_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      odd_cnt_q   <= odd_cnt_d;
    end
  end

  parity_core #(.DW(DW)) u_parity_core (
    .clk  (clk),
    .rst  (rst),
    .en   (core_en),
    .word (word_q),
    .par  (core_par)
  );

  assign ack       = ack_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_par   = core_par;
  assign odd_cnt   = odd_cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_parity_arbiter.sv
// Directed bench for parity_arbiter with a transaction-level reference model.
module tb_parity_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDW  = 2;
  localparam int CW   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] data = '0;
  logic               res_ready = 1'b0;
  logic [NREQ-1:0]    ack;
  logic               res_valid;
  logic [IDW-1:0]     res_id;
  logic               res_par;
  logic [CW-1:0]      odd_cnt;
  logic               busy;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  parity_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_par   (res_par),
    .odd_cnt   (odd_cnt),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_age < 0 means free, 0 means just granted, 1 means result outstanding.
  int              m_age  = -1;
  logic [NREQ-1:0] m_ack  = '0;
  bit              m_valid = 1'b0;
  int              m_id   = 0;
  int              m_par  = 0;
  int              m_odd  = 0;
  int              m_last = NREQ - 1;
  int              m_gid  = 0;
  logic [DW-1:0]   m_word = '0;

  always @(posedge clk) begin : model
    int g;
    if (!rst) begin
      m_age   <= -1;
      m_ack   <= '0;
      m_valid <= 1'b0;
      m_id    <= 0;
      m_par   <= 0;
      m_odd   <= 0;
      m_last  <= NREQ - 1;
      started <= 1'b1;
    end else begin
      m_ack <= '0;
      if (m_age < 0) begin
        if (req != 0) begin
          g = -1;
          for (int k = 1; k <= NREQ; k++) begin
            if (g < 0 && req[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
          end
          m_gid  <= g;
          m_word <= data[g*DW +: DW];
          m_ack  <= NREQ'(1 << g);
          m_last <= g;
          m_age  <= 0;
        end
      end else if (m_age == 0) begin
        m_valid <= 1'b1;
        m_id    <= m_gid;
        m_par   <= $countones(m_word) % 2;
        m_age   <= 1;
      end else if (res_ready) begin
        m_valid <= 1'b0;
        m_age   <= -1;
        if (m_par == 1 && m_odd < 255) m_odd <= m_odd + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc ack", ack, m_ack);
      chk("cyc res_valid", res_valid, m_valid);
      chk("cyc res_id", res_id, m_id);
      chk("cyc res_par", res_par, m_par);
      chk("cyc odd_cnt", odd_cnt, m_odd);
      chk("cyc busy", busy, m_age >= 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("idle timeout", busy, 0);
  endtask

  initial begin
    int gseq[6];
    int gcyc[6];
    int n;
    int acc;

    // Reset with all requests high
    rst = 1'b0; req = 4'b1111; data = '0; res_ready = 1'b1;
    tick(); tick();
    chk("rst ack", ack, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst odd_cnt", odd_cnt, 0);
    chk("rst busy", busy, 0);
    rst = 1'b1;
    tick();
    chk("first ack", ack, 4'b0001);
    req = '0;
    wait_idle();

    // Single request, odd then even word
    data[7:0] = 8'hA7; req = 4'b0001;
    tick();
    chk("single ack", ack, 4'b0001);
    req = '0;
    tick();
    chk("single valid", res_valid, 1);
    chk("single id", res_id, 0);
    chk("single par", res_par, 1);
    tick();
    chk("single valid drop", res_valid, 0);
    chk("single odd_cnt", odd_cnt, 1);
    data[7:0] = 8'h00; req = 4'b0001;
    tick();
    req = '0;
    tick();
    chk("even valid", res_valid, 1);
    chk("even par", res_par, 0);
    tick();
    chk("even odd_cnt", odd_cnt, 1);

    // Fairness from a fresh reset
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    data = {8'h0F, 8'h07, 8'h03, 8'h01};
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin gseq[i] = -1; gcyc[i] = -100; end
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick();
      if (ack != 0) begin
        for (int j = 0; j < NREQ; j++) if (ack[j]) gseq[n] = j;
        gcyc[n] = c;
        n++;
      end
    end
    req = '0;
    chk("fair count", n, 6);
    for (int i = 0; i < 6; i++) chk("fair grant", gseq[i], i % 4);
    for (int i = 1; i < 6; i++) chk("fair spacing", gcyc[i] - gcyc[i-1], 3);
    wait_idle();

    // Backpressure
    res_ready = 1'b0;
    data[7:0] = 8'hA7; data[15:8] = 8'h11; data[23:16] = 8'h13;
    req = 4'b0001;
    tick();
    chk("bp ack", ack, 4'b0001);
    req = 4'b0110;
    tick();
    chk("bp valid", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp hold valid", res_valid, 1);
      chk("bp hold id", res_id, 0);
      chk("bp hold par", res_par, 1);
      chk("bp hold ack", ack, 0);
      chk("bp hold busy", busy, 1);
    end
    res_ready = 1'b1;
    tick();
    chk("bp valid drop", res_valid, 0);
    chk("bp idle", busy, 0);
    tick();
    chk("bp next ack", ack, 4'b0010);
    req = '0;
    wait_idle();

    // Reset during EVAL
    req = 4'b0100;
    tick();
    chk("mid ack", ack, 4'b0100);
    rst = 1'b0; req = 4'b1010;
    tick();
    chk("mid valid", res_valid, 0);
    chk("mid busy", busy, 0);
    chk("mid ack clr", ack, 0);
    rst = 1'b1;
    tick();
    chk("mid regrant", ack, 4'b0010);
    req = '0;
    wait_idle();

    // Counter saturation
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    data[7:0] = 8'h01; req = 4'b0001; res_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 1200 && acc < 260; c++) begin
      tick();
      if (res_valid) acc++;
    end
    tick();
    chk("sat results", acc, 260);
    chk("sat odd_cnt", odd_cnt, 255);
    for (int i = 0; i < 6; i++) tick();
    chk("sat sticks", odd_cnt, 255);
    req = '0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
